// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point helpers for the NN datapath.
// Provides:
//   Q_DW, Q_FRAC - default Q-format word width and fractional bits
//   sat_res_t    - result of a saturating narrow (clipped value + flag)
//   clog2        - ceil(log2(n)) for elaboration-time sizing
//   sat_to_dw    - clip a signed value (up to 64 bits) into a dw-bit signed range
package nn_fixed_pkg;

  localparam int Q_DW   = 16;
  localparam int Q_FRAC = 8;

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } sat_res_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Caller takes the low dw bits of val; the flag marks a clipped value.
  function automatic sat_res_t sat_to_dw(input logic signed [63:0] x, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    r.sat = 1'b0;
    r.val = x;
    if (x > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (x < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Registered binary adder tree with a valid/sideband pipeline.
// Every level is one register stage; latency is clog2(N) cycles. Sums keep
// the full W bits at every level, so the caller sizes W for growth.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (valid bits only)
//   in_valid   - input vector present
//   in_sb      - SB_W-bit sideband travelling with the vector
//   in_data    - N signed W-bit leaves, leaf i at [i*W +: W]
//   out_valid  - sum valid
//   out_sb     - sideband aligned with out_data
//   out_data   - signed W-bit total
module mac_adder_tree
  import nn_fixed_pkg::*;
#(
  parameter int N    = 16,
  parameter int W    = 40,
  parameter int SB_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [SB_W-1:0]   in_sb,
  input  logic [N*W-1:0]    in_data,
  output logic              out_valid,
  output logic [SB_W-1:0]   out_sb,
  output logic [W-1:0]      out_data
);

  localparam int LEVELS = clog2(N);

  // Registered nodes of all levels packed flat: level l (1-based) holds N>>l
  // nodes starting at N - 2*(N>>l); the root is the last entry.
  logic signed [W-1:0] node_p [N-1];
  logic [LEVELS-1:0]   vld_p;
  logic [SB_W-1:0]     sb_p [LEVELS];

  function automatic int lvl_off(input int l);
    return N - 2 * (N >> l);
  endfunction

  // Level 1 reads leaves, so its node index is never used; keep it in range.
  function automatic int src_idx(input int l, input int j, input int b);
    return (l == 1) ? 0 : lvl_off(l - 1) + 2 * j + b;
  endfunction

  // ---- tree levels 1..LEVELS ----
  always_ff @(posedge clk) begin
    for (int l = 1; l <= LEVELS; l++) begin
      for (int j = 0; j < (N >> l); j++) begin
        node_p[lvl_off(l) + j] <=
          ((l == 1) ? $signed(in_data[(2 * j) * W +: W])     : node_p[src_idx(l, j, 0)]) +
          ((l == 1) ? $signed(in_data[(2 * j + 1) * W +: W]) : node_p[src_idx(l, j, 1)]);
      end
    end
    sb_p[0] <= in_sb;
    for (int l = 1; l < LEVELS; l++) sb_p[l] <= sb_p[l - 1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_valid;
      for (int l = 1; l < LEVELS; l++) vld_p[l] <= vld_p[l - 1];
    end
  end

  assign out_valid = vld_p[LEVELS-1];
  assign out_sb    = sb_p[LEVELS-1];
  assign out_data  = node_p[N-2];

endmodule

// File: rtl/mac_dot_acc.sv
// Pipelined fixed-point dot-product engine with multi-beat accumulation.
// Each accepted beat multiplies LANES activation/weight pairs, renormalises
// every product by FRAC+shift (floor), sums them in a registered tree and
// folds the sum into an accumulator; the last beat of a vector emits the
// saturated DW-bit result. Per-lane saturated products are tapped as well.
// Latency: MULT_LAT+clog2(LANES)+2 to out_valid, MULT_LAT+1 to prod_valid.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid          - beat present (no backpressure)
//   in_first/in_last  - vector delimiters (may both be set)
//   din, weight       - LANES signed DW-bit lanes, lane i at [i*DW +: DW]
//   bias              - added to the accumulator on a first beat
//   shift             - extra arithmetic right shift of this beat's products
//   out_valid         - one-cycle pulse with channel_sum/sat
//   channel_sum, sat  - saturated vector result and clip flag
//   prod_valid, prod  - per-lane saturated renormalised products
module mac_dot_acc
  import nn_fixed_pkg::*;
#(
  parameter int DW       = Q_DW,
  parameter int FRAC     = Q_FRAC,
  parameter int LANES    = 16,
  parameter int ACC_W    = 40,
  parameter int MULT_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [DW*LANES-1:0]   din,
  input  logic [DW*LANES-1:0]   weight,
  input  logic [DW-1:0]         bias,
  input  logic [1:0]            shift,
  output logic                  out_valid,
  output logic [DW-1:0]         channel_sum,
  output logic                  sat,
  output logic                  prod_valid,
  output logic [DW*LANES-1:0]   prod
);

  localparam int PW = 2 * DW;

  typedef struct packed {
    logic          first;
    logic          last;
    logic [1:0]    shift;
    logic [DW-1:0] bias;
  } sb_t;

  function automatic logic signed [ACC_W-1:0] renorm(input logic signed [PW-1:0] p,
                                                     input logic [1:0] sh);
    logic signed [PW-1:0] s;
    s = p >>> (FRAC + 32'(sh));
    return ACC_W'(s);
  endfunction

  // {clip flag, DW-bit clipped value}
  function automatic logic [DW:0] clip(input logic signed [ACC_W-1:0] a);
    sat_res_t r;
    r = sat_to_dw(64'(a), DW);
    return {r.sat, r.val[DW-1:0]};
  endfunction

  logic signed [PW-1:0]    mul_p0 [MULT_LAT][LANES];
  sb_t                     sb_p0  [MULT_LAT];
  logic [MULT_LAT-1:0]     vld_p0;

  logic [LANES*ACC_W-1:0]  tree_in;
  logic [LANES*DW-1:0]     prod_sat;
  logic signed [ACC_W-1:0] shv;
  logic [DW:0]             pclip;

  logic [LANES*DW-1:0]     prod_p1;
  logic                    vld_p1;

  logic                    tree_vld;
  logic [DW+1:0]           tree_sb;
  logic [ACC_W-1:0]        tree_sum;

  logic signed [ACC_W-1:0] acc_p2;
  logic                    last_vld_p2;

  logic [DW-1:0]           sum_p3;
  logic                    sat_p3;
  logic                    vld_p3;

  // ---- multiplier stages 0..MULT_LAT-1 ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      mul_p0[0][i] <= PW'($signed(din[i*DW +: DW])) * PW'($signed(weight[i*DW +: DW]));
    end
    sb_p0[0] <= {in_first, in_last, shift, bias};
    for (int k = 1; k < MULT_LAT; k++) begin
      mul_p0[k] <= mul_p0[k-1];
      sb_p0[k]  <= sb_p0[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= '0;
    end else begin
      vld_p0[0] <= in_valid;
      for (int k = 1; k < MULT_LAT; k++) vld_p0[k] <= vld_p0[k-1];
    end
  end

  always_comb begin
    tree_in  = '0;
    prod_sat = '0;
    shv      = '0;
    pclip    = '0;
    for (int i = 0; i < LANES; i++) begin
      shv   = renorm(mul_p0[MULT_LAT-1][i], sb_p0[MULT_LAT-1].shift);
      pclip = clip(shv);
      tree_in[i*ACC_W +: ACC_W] = shv;
      prod_sat[i*DW +: DW]      = pclip[DW-1:0];
    end
  end

  // ---- product tap register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      prod_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0[MULT_LAT-1];
      if (vld_p0[MULT_LAT-1]) prod_p1 <= prod_sat;
    end
  end

  // ---- adder tree ----
  mac_adder_tree #(
    .N    (LANES),
    .W    (ACC_W),
    .SB_W (DW + 2)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p0[MULT_LAT-1]),
    .in_sb     ({sb_p0[MULT_LAT-1].first, sb_p0[MULT_LAT-1].last, sb_p0[MULT_LAT-1].bias}),
    .in_data   (tree_in),
    .out_valid (tree_vld),
    .out_sb    (tree_sb),
    .out_data  (tree_sum)
  );

  // ---- accumulator ----
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2      <= '0;
      last_vld_p2 <= 1'b0;
    end else begin
      last_vld_p2 <= tree_vld & tree_sb[DW];
      if (tree_vld) begin
        acc_p2 <= (tree_sb[DW+1] ? ACC_W'($signed(tree_sb[DW-1:0])) : acc_p2) + $signed(tree_sum);
      end
    end
  end

  // ---- saturation / output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3 <= 1'b0;
      sum_p3 <= '0;
      sat_p3 <= 1'b0;
    end else begin
      vld_p3 <= last_vld_p2;
      if (last_vld_p2) {sat_p3, sum_p3} <= clip(acc_p2);
    end
  end

  assign out_valid   = vld_p3;
  assign channel_sum = sum_p3;
  assign sat         = sat_p3;
  assign prod_valid  = vld_p1;
  assign prod        = prod_p1;

endmodule

// File: tb/tb_mac_dot_acc.sv
module tb_mac_dot_acc;

  localparam int DW    = 16;
  localparam int LANES = 16;
  localparam int PWID  = DW * LANES;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_first;
  logic            in_last;
  logic [PWID-1:0] din;
  logic [PWID-1:0] weight;
  logic [DW-1:0]   bias;
  logic [1:0]      shift;
  logic            out_valid;
  logic [DW-1:0]   channel_sum;
  logic            sat;
  logic            prod_valid;
  logic [PWID-1:0] prod;

  mac_dot_acc dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .in_last     (in_last),
    .din         (din),
    .weight      (weight),
    .bias        (bias),
    .shift       (shift),
    .out_valid   (out_valid),
    .channel_sum (channel_sum),
    .sat         (sat),
    .prod_valid  (prod_valid),
    .prod        (prod)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            ov_cyc [$];
  logic [DW-1:0] ov_sum [$];
  logic          ov_sat [$];
  int            pv_cyc [$];
  logic [PWID-1:0] pv_val [$];

  always @(negedge clk) begin
    if (out_valid) begin
      ov_cyc.push_back(cyc);
      ov_sum.push_back(channel_sum);
      ov_sat.push_back(sat);
    end
    if (prod_valid) begin
      pv_cyc.push_back(cyc);
      pv_val.push_back(prod);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int drv_cyc;

  task automatic check(input string tag, input logic [PWID-1:0] obs, input logic [PWID-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clearq();
    ov_cyc.delete(); ov_sum.delete(); ov_sat.delete();
    pv_cyc.delete(); pv_val.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic f, input logic l, input logic [DW-1:0] d,
                      input logic [DW-1:0] w, input logic [DW-1:0] b, input logic [1:0] sh);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    din      = {LANES{d}};
    weight   = {LANES{w}};
    bias     = b;
    shift    = sh;
    drv_cyc  = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int t0;
    logic [DW-1:0] kval;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    din = '0; weight = '0; bias = '0; shift = '0;
    idle(3);
    check("rst_out_valid",   PWID'(out_valid),   '0);
    check("rst_prod_valid",  PWID'(prod_valid),  '0);
    check("rst_sat",         PWID'(sat),         '0);
    check("rst_channel_sum", PWID'(channel_sum), '0);
    check("rst_prod",        prod,               '0);
    rst = 1'b0;
    idle(2);
    check("idle_no_out", PWID'(ov_cyc.size()), PWID'(0));

    // single beat 1.0 * 1.0 on every lane
    clearq();
    beat(1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0000, 2'd0);
    t0 = drv_cyc;
    idle(14);
    check("single_count",   PWID'(ov_cyc.size()), PWID'(1));
    check("single_sum",     PWID'(ov_sum[0]), PWID'(16'h1000));
    check("single_sat",     PWID'(ov_sat[0]), PWID'(0));
    check("single_latency", PWID'(ov_cyc[0] - t0), PWID'(9));
    check("single_pcount",  PWID'(pv_cyc.size()), PWID'(1));
    check("single_plat",    PWID'(pv_cyc[0] - t0), PWID'(4));
    check("single_prod",    pv_val[0], {LANES{16'h0100}});

    // four-beat vector with bubbles, bias 1.0
    clearq();
    beat(1'b1, 1'b0, 16'h0080, 16'h0200, 16'h0100, 2'd0);
    beat(1'b0, 1'b0, 16'h0080, 16'h0200, 16'h0000, 2'd0);
    idle(2);
    beat(1'b0, 1'b0, 16'h0080, 16'h0200, 16'h0000, 2'd0);
    beat(1'b0, 1'b1, 16'h0080, 16'h0200, 16'h0000, 2'd0);
    t0 = drv_cyc;
    idle(14);
    check("vec4_count",   PWID'(ov_cyc.size()), PWID'(1));
    check("vec4_sum",     PWID'(ov_sum[0]), PWID'(16'h4100));
    check("vec4_sat",     PWID'(ov_sat[0]), PWID'(0));
    check("vec4_latency", PWID'(ov_cyc[0] - t0), PWID'(9));

    // saturation both directions
    clearq();
    beat(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 16'h0000, 2'd0);
    beat(1'b1, 1'b1, 16'h8001, 16'h7FFF, 16'h0000, 2'd0);
    idle(14);
    check("sat_count",    PWID'(ov_cyc.size()), PWID'(2));
    check("sat_pos_sum",  PWID'(ov_sum[0]), PWID'(16'h7FFF));
    check("sat_pos_flag", PWID'(ov_sat[0]), PWID'(1));
    check("sat_neg_sum",  PWID'(ov_sum[1]), PWID'(16'h8000));
    check("sat_neg_flag", PWID'(ov_sat[1]), PWID'(1));
    check("sat_pos_prod", pv_val[0], {LANES{16'h7FFF}});
    check("sat_neg_prod", pv_val[1], {LANES{16'h8000}});

    // negative operand, with and without extra shift
    clearq();
    beat(1'b1, 1'b1, 16'hFF00, 16'h0100, 16'h0000, 2'd0);
    beat(1'b1, 1'b1, 16'hFF00, 16'h0100, 16'h0000, 2'd2);
    idle(14);
    check("sign_count",  PWID'(ov_cyc.size()), PWID'(2));
    check("sign_sum0",   PWID'(ov_sum[0]), PWID'(16'hF000));
    check("sign_sat0",   PWID'(ov_sat[0]), PWID'(0));
    check("sign_sum2",   PWID'(ov_sum[1]), PWID'(16'hFC00));
    check("sign_sat2",   PWID'(ov_sat[1]), PWID'(0));
    check("sign_prod0",  pv_val[0], {LANES{16'hFF00}});
    check("sign_prod2",  pv_val[1], {LANES{16'hFFC0}});

    // back-to-back single-beat vectors
    clearq();
    for (int k = 0; k < 8; k++) begin
      kval = 16'(k * 256);
      beat(1'b1, 1'b1, kval, 16'h0100, 16'h0000, 2'd0);
    end
    idle(14);
    check("b2b_count", PWID'(ov_cyc.size()), PWID'(8));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("b2b_sum%0d", k), PWID'(ov_sum[k]), PWID'(16'(k * 4096)));
      check($sformatf("b2b_cyc%0d", k), PWID'(ov_cyc[k] - ov_cyc[0]), PWID'(k));
    end

    // reset in the middle of a three-beat vector
    clearq();
    beat(1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0010, 2'd0);
    beat(1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0000, 2'd0);
    beat(1'b0, 1'b1, 16'h0100, 16'h0100, 16'h0000, 2'd0);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clearq();
    check("midrst_channel_sum", PWID'(channel_sum), '0);
    check("midrst_sat",         PWID'(sat),         '0);
    check("midrst_prod",        prod,               '0);
    idle(1);
    rst = 1'b0;
    idle(20);
    check("midrst_no_out",  PWID'(ov_cyc.size()), PWID'(0));
    check("midrst_no_prod", PWID'(pv_cyc.size()), PWID'(0));

    // orphan beat onto cleared acc, then fresh vector loading bias
    clearq();
    beat(1'b0, 1'b1, 16'h0100, 16'h0100, 16'h0000, 2'd0);
    beat(1'b1, 1'b1, 16'h0100, 16'h0100, 16'h0050, 2'd0);
    t0 = drv_cyc;
    idle(14);
    check("post_count",   PWID'(ov_cyc.size()), PWID'(2));
    check("post_orphan",  PWID'(ov_sum[0]), PWID'(16'h1000));
    check("post_fresh",   PWID'(ov_sum[1]), PWID'(16'h1050));
    check("post_latency", PWID'(ov_cyc[1] - t0), PWID'(9));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
